// File: rtl/grant_hold_arb_if.sv
// ---------------------------------------------------------------------------
// grant_hold_arb_if
// Requester-side bus of the grant-hold arbiter.
//   req       N  level request per requester
//   en        1  arbitration enable (gates issuing a new grant)
//   rel       1  current owner done (the "release" strobe; renamed because
//                release is a reserved word in SystemVerilog)
//   gnt       N  registered one-hot grant, zero when no owner
//   gnt_valid 1  registered, high iff gnt != 0
//   req_up    1  OR of the pending register
//   pending   N  registered pending-request vector
//   timeout   1  one-cycle pulse when a grant is force-returned
// Modports: master = requester/test side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface grant_hold_arb_if #(
    parameter int N = 4
);
    logic [N-1:0] req;
    logic         en;
    logic         rel;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic         req_up;
    logic [N-1:0] pending;
    logic         timeout;

    modport master (
        output req, en, rel,
        input  gnt, gnt_valid, req_up, pending, timeout
    );

    modport slave (
        input  req, en, rel,
        output gnt, gnt_valid, req_up, pending, timeout
    );
endinterface

// File: rtl/grant_hold_arb.sv
// ---------------------------------------------------------------------------
// grant_hold_arb
// Sequential arbiter front-end: latches requests into a pending vector, picks
// one winner when enabled, then holds a registered one-hot grant until the
// owner releases it or the hold timeout expires.
//
// Ports:
//   clock  in  single clock, rising edge
//   reset  in  synchronous, active-high
//   bus    grant_hold_arb_if.slave (req/en/rel in; gnt/gnt_valid/req_up/
//          pending/timeout out)
// Parameters:
//   N         number of requesters (power of 2, 2..16)
//   MAX_HOLD  cycles a grant may be held before it is forced back (>= 2)
// Build option:
//   ARB_ROUND_ROBIN_EN  defined: rotating priority, the last granted index
//                       becomes lowest priority for the next issue.
//                       undefined: fixed priority, index N-1 highest.
// ---------------------------------------------------------------------------
module grant_hold_arb #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic             clock,
    input  logic             reset,
    grant_hold_arb_if.slave  bus
);
    localparam int CW = $clog2(MAX_HOLD);
    localparam int IW = $clog2(N);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q,    state_d;
    logic [N-1:0]  pending_q,  pending_d;
    logic [N-1:0]  gnt_q,      gnt_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          timeout_q,  timeout_d;
    logic [N-1:0]  issue_mask;
    logic [IW-1:0] win_idx;
    logic          win_found;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] cand;

    // Walk k-1, k-2, ... wrapping through N-1 down to k; N is a power of
    // two so the IW-bit subtraction wraps modulo N for free.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 1; i <= N; i++) begin
            cand = rr_ptr_q - IW'(i);
            if (!win_found && pending_q[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end
`else
    // Fixed priority: highest set index wins.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!win_found && pending_q[i]) begin
                win_idx   = IW'(i);
                win_found = 1'b1;
            end
        end
    end
`endif

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        issue_mask = '0;
        case (state_q)
            IDLE: begin
                if (bus.en && win_found) begin
                    issue_mask[win_idx] = 1'b1;
                    gnt_d               = issue_mask;
                    hold_cnt_d          = '0;
                    state_d             = BUSY;
                end
            end
            BUSY: begin
                // Release takes precedence over an expiring hold: no pulse.
                if (bus.rel) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (hold_cnt_q == CW'(MAX_HOLD - 1)) begin
                    gnt_d     = '0;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_valid_d = |gnt_d;
        // A same-cycle request on the issued index re-sets its bit.
        pending_d   = (pending_q & ~issue_mask) | bus.req;
    end

`ifdef ARB_ROUND_ROBIN_EN
    assign rr_ptr_d = (|issue_mask) ? win_idx : rr_ptr_q;
`endif

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            pending_q   <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= IW'(N - 1);
`endif
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.pending   = pending_q;
    assign bus.req_up    = |pending_q;
    assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_grant_hold_arb.sv
// ---------------------------------------------------------------------------
// tb_grant_hold_arb
// Drives directed and random stimulus into grant_hold_arb. A behavioural
// model (owner index, cycles held, pending bit set) predicts the outputs
// after each clock edge and queues them; an independent monitor pops and
// compares one expectation per edge. Follows ARB_ROUND_ROBIN_EN like the DUT.
// ---------------------------------------------------------------------------
module tb_grant_hold_arb;
    localparam int N        = 4;
    localparam int MAX_HOLD = 8;

    typedef struct packed {
        logic [N-1:0] gnt;
        logic         gv;
        logic [N-1:0] pend;
        logic         up;
        logic         to;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    grant_hold_arb_if #(.N(N)) bus ();

    grant_hold_arb #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state.
    logic [N-1:0] m_pend  = '0;
    int           m_owner = -1;   // index holding the grant, -1 when none
    int           m_held  = 0;    // cycles the grant has been visible
    logic         m_to    = 1'b0;
    int           m_ptr   = N - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_checks++;
        if (act === req_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req_v, $time);
    endtask

    function automatic int pick(input logic [N-1:0] p, input int ptr);
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= N; i++)
            if (p[(ptr - i + N) % N]) return (ptr - i + N) % N;
`else
        for (int i = N - 1; i >= 0; i--)
            if (p[i]) return i + 0 * ptr;
`endif
        return -1;
    endfunction

    // Apply one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [N-1:0] r, input logic e, input logic rl, input logic rs);
        exp_t x;
        int   issue;
        @(negedge clock);
        bus.req = r;
        bus.en  = e;
        bus.rel = rl;
        reset   = rs;
        issue   = -1;
        if (rs) begin
            m_pend  = '0;
            m_owner = -1;
            m_held  = 0;
            m_to    = 1'b0;
            m_ptr   = N - 1;
        end else begin
            m_to = 1'b0;
            if (m_owner < 0) begin
                if (e && m_pend != '0) begin
                    issue   = pick(m_pend, m_ptr);
                    m_owner = issue;
                    m_held  = 1;
                    m_ptr   = issue;
                end
            end else if (rl) begin
                m_owner = -1;
            end else if (m_held == MAX_HOLD) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held++;
            end
            if (issue >= 0) m_pend[issue] = 1'b0;
            m_pend = m_pend | r;
        end
        x.gnt  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        x.gv   = (m_owner >= 0);
        x.pend = m_pend;
        x.up   = (m_pend != '0);
        x.to   = m_to;
        exp_q.push_back(x);
    endtask

    // Monitor: one expectation per rising edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("gnt",       32'(bus.gnt),       32'(e.gnt));
                check("gnt_valid", 32'(bus.gnt_valid), 32'(e.gv));
                check("pending",   32'(bus.pending),   32'(e.pend));
                check("req_up",    32'(bus.req_up),    32'(e.up));
                check("timeout",   32'(bus.timeout),   32'(e.to));
            end
        end
    end

    initial begin
        bus.req = '0;
        bus.en  = 1'b0;
        bus.rel = 1'b0;

        // Reset held two cycles with all requests up.
        step(4'hF, 1'b1, 1'b0, 1'b1);
        step(4'hF, 1'b1, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0, 1'b0);

        // Two requests at once: higher index first, then the lower one.
        step(4'b0101, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0);
        step(4'b0000, 1'b0, 1'b1, 1'b0);   // release in IDLE ignored

        // Hold timeout: never released.
        step(4'b0010, 1'b1, 1'b0, 1'b0);
        repeat (12) step(4'b0000, 1'b1, 1'b0, 1'b0);

        // Enable gating.
        step(4'b1000, 1'b0, 1'b0, 1'b0);
        repeat (5) step(4'b0000, 1'b0, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 1'b0);

        // req[3] held: early releases, then release on the final hold cycle.
        step(4'b1000, 1'b1, 1'b0, 1'b0);
        repeat (3) begin
            step(4'b1000, 1'b1, 1'b0, 1'b0);
            step(4'b1000, 1'b1, 1'b0, 1'b0);
            step(4'b1000, 1'b1, 1'b1, 1'b0);
        end
        while (m_owner < 0) step(4'b1000, 1'b1, 1'b0, 1'b0);
        while (m_held < MAX_HOLD) step(4'b1000, 1'b1, 1'b0, 1'b0);
        step(4'b1000, 1'b1, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b1, 1'b0);

        // All requesting, each grant released as soon as it appears.
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        repeat (12) step(4'hF, 1'b1, (m_owner >= 0), 1'b0);

        // Mid-grant reset drops the grant without a timeout pulse.
        step(4'b0100, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0, 1'b1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step(N'($urandom),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 199) == 0));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
        #2;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
